systolic_array_4x4: RTL

- Output-stationary 4x4 int8 systolic array. It sits directly downstream of the TPU control FSM.
- Consumes the four A words and four B words that the FSM stages for one K-chunk of 4, computes a 4x4 partial product tile, and returns four 128-bit C rows plus a done flag.
- The FSM accumulates returned tiles across K-chunks; this block computes exactly one chunk per sa_rst_n-high window.

---
 rtl/systolic_array_4x4.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/systolic_array_4x4.sv
// Output-stationary 4x4 int8 systolic array: computes one K=4 partial product tile
// per sa_rst_n-high window and holds the result with done until the next clear.
module systolic_array_4x4 #(
  parameter int DATA_BITS  = 32,
  parameter int ELEM_BITS  = 8,
  parameter int ACC_BITS   = 32,
  parameter int DATAC_BITS = 128
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  sa_rst_n,
  input  logic [DATA_BITS-1:0]  a0,
  input  logic [DATA_BITS-1:0]  a1,
  input  logic [DATA_BITS-1:0]  a2,
  input  logic [DATA_BITS-1:0]  a3,
  input  logic [DATA_BITS-1:0]  b0,
  input  logic [DATA_BITS-1:0]  b1,
  input  logic [DATA_BITS-1:0]  b2,
  input  logic [DATA_BITS-1:0]  b3,
  output logic [DATAC_BITS-1:0] c0,
  output logic [DATAC_BITS-1:0] c1,
  output logic [DATAC_BITS-1:0] c2,
  output logic [DATAC_BITS-1:0] c3,
  output logic                  done
);

  localparam int N = 4;
  localparam logic [3:0] CNT_LAST = 4'd10;

  // Elements are packed MSB first: element e sits at the top of the word for e=0.
  function automatic logic [ELEM_BITS-1:0] elem_sel(input logic [DATA_BITS-1:0] w, input int e);
    return w[DATA_BITS-1-ELEM_BITS*e -: ELEM_BITS];
  endfunction

  logic [DATA_BITS-1:0]  a_w [N];
  logic [DATA_BITS-1:0]  b_w [N];
  logic [ELEM_BITS-1:0]  a_in_s [N];
  logic [ELEM_BITS-1:0]  b_in_s [N];
  logic [3:0]            ka_s [N];
  logic [3:0]            kb_s [N];
  logic [ELEM_BITS-1:0]  a_op_s [N][N];
  logic [ELEM_BITS-1:0]  b_op_s [N][N];
  logic [ELEM_BITS-1:0]  a_pipe_q [N][N-1];
  logic [ELEM_BITS-1:0]  b_pipe_q [N-1][N];
  logic [ACC_BITS-1:0]   acc_q [N][N];
  logic [ACC_BITS-1:0]   acc_d [N][N];
  logic [DATAC_BITS-1:0] c_s [N];
  logic [3:0]            cnt_q;
  logic [3:0]            cnt_d;
  logic                  done_q;
  logic                  done_d;
  logic                  clear_s;

  assign a_w[0] = a0;
  assign a_w[1] = a1;
  assign a_w[2] = a2;
  assign a_w[3] = a3;
  assign b_w[0] = b0;
  assign b_w[1] = b1;
  assign b_w[2] = b2;
  assign b_w[3] = b3;

  assign clear_s = (!rst_n) || (!sa_rst_n);

  // Edge injection: row i gets A[i][cnt-i], column i gets B[cnt-i][i], zero outside 0..3.
  always_comb begin
    for (int i = 0; i < N; i++) begin
      ka_s[i]   = cnt_q - 4'(i);
      kb_s[i]   = cnt_q - 4'(i);
      a_in_s[i] = '0;
      b_in_s[i] = '0;
      if ((cnt_q >= 4'(i)) && (ka_s[i] <= 4'd3)) begin
        a_in_s[i] = elem_sel(a_w[ka_s[i][1:0]], i);
      end else begin
        a_in_s[i] = '0;
      end
      if ((cnt_q >= 4'(i)) && (kb_s[i] <= 4'd3)) begin
        b_in_s[i] = elem_sel(b_w[kb_s[i][1:0]], i);
      end else begin
        b_in_s[i] = '0;
      end
    end
  end

  for (genvar m = 0; m < N; m++) begin : g_row
    for (genvar n = 0; n < N; n++) begin : g_col
      logic signed [2*ELEM_BITS-1:0] prod_s;

      if (n == 0) begin : g_a_edge
        assign a_op_s[m][n] = a_in_s[m];
      end else begin : g_a_hop
        assign a_op_s[m][n] = a_pipe_q[m][n-1];
      end

      if (m == 0) begin : g_b_edge
        assign b_op_s[m][n] = b_in_s[n];
      end else begin : g_b_hop
        assign b_op_s[m][n] = b_pipe_q[m-1][n];
      end

      // Zero operands outside the active diagonal make the MAC a no-op.
      assign prod_s = $signed(a_op_s[m][n]) * $signed(b_op_s[m][n]);
      assign acc_d[m][n] = acc_q[m][n]
                         + {{(ACC_BITS-2*ELEM_BITS){prod_s[2*ELEM_BITS-1]}}, prod_s};

      // Per-PE accumulator register.
      always_ff @(posedge clk) begin
        if (clear_s) begin
          acc_q[m][n] <= '0;
        end else begin
          acc_q[m][n] <= acc_d[m][n];
        end
      end

      if (n < N-1) begin : g_a_reg
        // A operand hop to the right-hand neighbour.
        always_ff @(posedge clk) begin
          if (clear_s) begin
            a_pipe_q[m][n] <= '0;
          end else begin
            a_pipe_q[m][n] <= a_op_s[m][n];
          end
        end
      end

      if (m < N-1) begin : g_b_reg
        // B operand hop to the neighbour below.
        always_ff @(posedge clk) begin
          if (clear_s) begin
            b_pipe_q[m][n] <= '0;
          end else begin
            b_pipe_q[m][n] <= b_op_s[m][n];
          end
        end
      end
    end

    assign c_s[m] = {acc_q[m][0], acc_q[m][1], acc_q[m][2], acc_q[m][3]};
  end

  // Saturating cycle counter; done follows it so it cannot drop inside a window.
  always_comb begin
    cnt_d  = cnt_q;
    done_d = done_q;
    if (cnt_q == CNT_LAST) begin
      cnt_d  = CNT_LAST;
      done_d = 1'b1;
    end else begin
      cnt_d  = cnt_q + 4'd1;
      done_d = 1'b0;
    end
  end

  // Counter and done registers.
  always_ff @(posedge clk) begin
    if (clear_s) begin
      cnt_q  <= 4'd0;
      done_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      done_q <= done_d;
    end
  end

  assign c0   = c_s[0];
  assign c1   = c_s[1];
  assign c2   = c_s[2];
  assign c3   = c_s[3];
  assign done = done_q;

endmodule
